// File: rtl/ocm_dual.sv
// True dual-port on-chip RAM with byte enables, read-valid strobes, a clear engine and A-priority collisions.
// Define OCM_OUTREG_EN to add an output register stage, which makes read latency 2 cycles.
module ocm_dual #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic                    a_we,
  input  logic                    a_re,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_rvalid,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic                    b_we,
  input  logic                    b_re,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_rvalid
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    run;
  logic [DATA_WIDTH-1:0]   a_rdata_s1, b_rdata_s1;
  logic                    a_rvalid_s1, b_rvalid_s1;

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end else if (state == CLEAR) begin
      sweep_addr <= sweep_addr + 1'b1;
      if (sweep_addr == {ADDR_WIDTH{1'b1}})
        state <= RUN;
    end else if (clear_req) begin
      state      <= CLEAR;
      sweep_addr <= '0;
    end
  end

  // Port B is written first so that port A's bytes override it on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[sweep_addr] <= CLEAR_VALUE;
      end else begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (b_we && b_be[i])
            mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
          if (a_we && a_be[i])
            mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid_s1 <= 1'b0;
      b_rvalid_s1 <= 1'b0;
      a_rdata_s1  <= '0;
      b_rdata_s1  <= '0;
    end else begin
      a_rvalid_s1 <= run && a_re;
      b_rvalid_s1 <= run && b_re;
      if (run && a_re)
        a_rdata_s1 <= mem[a_addr];
      if (run && b_re)
        b_rdata_s1 <= mem[b_addr];
    end
  end

`ifdef OCM_OUTREG_EN
  // The first stage already holds its data between reads, so a plain copy keeps that behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rvalid_s1;
      b_rvalid <= b_rvalid_s1;
      a_rdata  <= a_rdata_s1;
      b_rdata  <= b_rdata_s1;
    end
  end
`else
  assign a_rvalid = a_rvalid_s1;
  assign b_rvalid = b_rvalid_s1;
  assign a_rdata  = a_rdata_s1;
  assign b_rdata  = b_rdata_s1;
`endif

endmodule

// File: tb/tb_ocm_dual.sv
// Self-checking bench for ocm_dual (16-bit words, 16 entries) against a word-array reference model.
module tb_ocm_dual;

  localparam int          DW    = 16;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CV    = 16'h00A5;
`ifdef OCM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, clear_req, busy;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [1:0]    a_be, b_be;
  logic          a_we, a_re, a_rvalid, b_we, b_re, b_rvalid;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles;

  logic [15:0] model_mem [DEPTH];
  int          clear_left;
  logic        pv_a [2], pv_b [2];
  logic [15:0] pd_a [2], pd_b [2];
  logic [15:0] last_a, last_b;

  ocm_dual #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be), .a_we(a_we), .a_re(a_re),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be), .b_we(b_we), .b_re(b_re),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a cycle counter for the sweep, a word array, and a shift queue per port.
  task automatic modelStep();
    logic        nv_a, nv_b;
    logic [15:0] nd_a, nd_b;
    if (reset) begin
      clear_left = DEPTH;
      for (int i = 0; i < 2; i++) begin
        pv_a[i] = 1'b0; pv_b[i] = 1'b0; pd_a[i] = '0; pd_b[i] = '0;
      end
      last_a = '0;
      last_b = '0;
      return;
    end
    nv_a = 1'b0; nv_b = 1'b0;
    if (clear_left > 0) begin
      model_mem[DEPTH - clear_left] = CV;
      clear_left--;
    end else begin
      if (a_re) begin nv_a = 1'b1; last_a = model_mem[a_addr]; end
      if (b_re) begin nv_b = 1'b1; last_b = model_mem[b_addr]; end
      for (int i = 0; i < 2; i++) begin
        if (b_we && b_be[i]) model_mem[b_addr][i*8 +: 8] = b_wdata[i*8 +: 8];
        if (a_we && a_be[i]) model_mem[a_addr][i*8 +: 8] = a_wdata[i*8 +: 8];
      end
      if (clear_req) clear_left = DEPTH;
    end
    nd_a = last_a;
    nd_b = last_b;
    pv_a[1] = pv_a[0]; pd_a[1] = pd_a[0]; pv_a[0] = nv_a; pd_a[0] = nd_a;
    pv_b[1] = pv_b[0]; pd_b[1] = pd_b[0]; pv_b[0] = nv_b; pd_b[0] = nd_b;
  endtask

  task automatic checkOutput();
    check("busy",     32'(busy),     32'(clear_left > 0));
    check("a_rvalid", 32'(a_rvalid), 32'(pv_a[LAT-1]));
    check("a_rdata",  32'(a_rdata),  32'(pd_a[LAT-1]));
    check("b_rvalid", 32'(b_rvalid), 32'(pv_b[LAT-1]));
    check("b_rdata",  32'(b_rdata),  32'(pd_b[LAT-1]));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    clear_req = 1'b0;
    a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0; a_re = 1'b0;
    b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic randomInputs(input logic allow_clear);
    a_addr = 4'($urandom); a_wdata = 16'($urandom); a_be = 2'($urandom);
    a_we = 1'($urandom); a_re = 1'($urandom);
    b_addr = 4'($urandom); b_wdata = 16'($urandom); b_be = 2'($urandom);
    b_we = 1'($urandom); b_re = 1'($urandom);
    b_addr = ($urandom_range(0, 3) == 0) ? a_addr : b_addr;
    clear_req = allow_clear && ($urandom_range(0, 63) == 0);
  endtask

  task automatic drain();
    idleInputs();
    for (int i = 1; i < LAT; i++) applyStimulus();
  endtask

  task automatic readCheck(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    idleInputs();
    a_re = 1'b1; a_addr = addr;
    applyStimulus();
    drain();
    check({tag, "_vld"}, 32'(a_rvalid), 32'd1);
    check(tag, 32'(a_rdata), 32'(exp));
  endtask

  task automatic fillMemory(input logic [15:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      idleInputs();
      a_we = 1'b1; a_be = 2'b11; a_addr = 4'(i); a_wdata = base + 16'(i);
      applyStimulus();
    end
    idleInputs();
  endtask

  // Counts busy cycles starting with the cycle after the triggering edge.
  task automatic countBusy(input int second_req_at, input string tag);
    idleInputs();
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      clear_req = (i == second_req_at);
      applyStimulus();
      if (busy) busy_cycles++;
    end
    clear_req = 1'b0;
    check(tag, 32'(busy_cycles), 32'd16);
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    check("reset_a_rdata", 32'(a_rdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;

    // Traffic during the power-up sweep must be ignored.
    busy_cycles = 1;
    for (int i = 0; i < 30 && busy; i++) begin
      randomInputs(1'b0);
      applyStimulus();
      if (busy) busy_cycles++;
    end
    check("init_busy_len", 32'(busy_cycles), 32'd16);
    idleInputs();

    for (int i = 0; i < DEPTH; i++) begin
      a_re = 1'b1; a_addr = 4'(i);
      b_re = 1'b1; b_addr = 4'(DEPTH - 1 - i);
      applyStimulus();
    end
    drain();
    readCheck(4'd9, CV, "cleared_word");

    // Port A writes, port B reads the next cycle.
    idleInputs();
    a_we = 1'b1; a_be = 2'b11; a_addr = 4'd5; a_wdata = 16'h003C;
    applyStimulus();
    idleInputs();
    b_re = 1'b1; b_addr = 4'd5;
    applyStimulus();
    drain();
    check("b_read_3c_vld", 32'(b_rvalid), 32'd1);
    check("b_read_3c", 32'(b_rdata), 32'h003C);

    // Byte-wise collision, A keeps priority on its enabled bytes.
    idleInputs();
    a_we = 1'b1; a_addr = 4'd7; a_be = 2'b01; a_wdata = 16'h1111;
    b_we = 1'b1; b_addr = 4'd7; b_be = 2'b11; b_wdata = 16'h2222;
    applyStimulus();
    readCheck(4'd7, 16'h2211, "collide_lo");
    idleInputs();
    a_we = 1'b1; a_addr = 4'd7; a_be = 2'b11; a_wdata = 16'h1111;
    b_we = 1'b1; b_addr = 4'd7; b_be = 2'b11; b_wdata = 16'h2222;
    applyStimulus();
    readCheck(4'd7, 16'h1111, "collide_all");

    // Read-first on a same-port read/write.
    idleInputs();
    a_we = 1'b1; a_be = 2'b11; a_addr = 4'd3; a_wdata = 16'hBEEF;
    applyStimulus();
    idleInputs();
    a_we = 1'b1; a_re = 1'b1; a_be = 2'b11; a_addr = 4'd3; a_wdata = 16'h1234;
    applyStimulus();
    drain();
    check("rw_old", 32'(a_rdata), 32'hBEEF);
    readCheck(4'd3, 16'h1234, "rw_new");

    // Software clear, with a second request mid-sweep.
    fillMemory(16'h5A00);
    clear_req = 1'b1;
    applyStimulus();
    countBusy(5, "clr_busy_len");
    for (int i = 0; i < DEPTH; i++) readCheck(4'(i), CV, "clr_word");

    // Reset drops an in-flight read.
    idleInputs();
    a_re = 1'b1; a_addr = 4'd2; b_re = 1'b1; b_addr = 4'd4;
    applyStimulus();
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    check("reset_drop_a", 32'(a_rvalid), 32'd0);
    check("reset_drop_b", 32'(b_rvalid), 32'd0);
    reset = 1'b0;
    countBusy(-1, "rst_busy_len");

    // Reset at sweep address 9 restarts a full sweep.
    fillMemory(16'hC300);
    clear_req = 1'b1;
    applyStimulus();
    idleInputs();
    repeat (9) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    countBusy(-1, "restart_busy_len");
    readCheck(4'd12, CV, "restart_word");

    for (int i = 0; i < 500; i++) begin
      randomInputs(1'b1);
      applyStimulus();
    end
    idleInputs();
    repeat (20) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
